// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer that owns the register file write
// port. It merges the load and ALU result paths into one queue of pending
// writes. It drains one write per cycle, and it forwards the youngest pending
// value for each read operand.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [AW-1:0]              mem_rd,
    input  logic [DW-1:0]              mem_data,
    input  logic                       hold,
    output logic                       rf_regwr,
    output logic [AW-1:0]              rf_rd,
    output logic [DW-1:0]              rf_datawr,
    input  logic [AW-1:0]              fwd_rn,
    input  logic [AW-1:0]              fwd_rm,
    output logic                       fwd_rn_hit,
    output logic                       fwd_rm_hit,
    output logic [DW-1:0]              fwd_rn_data,
    output logic [DW-1:0]              fwd_rm_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] XZR = '1;

    logic [AW-1:0] entry_rd   [DEPTH];
    logic [DW-1:0] entry_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_rd;
    logic [DW-1:0] push_data;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // The load path has fixed priority. Full blocks both paths even when a
    // pop is in progress, so ready depends only on registered state and on
    // mem_valid.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign push_rd   = mem_valid ? mem_rd : alu_rd;
    assign push_data = mem_valid ? mem_data : alu_data;
    assign accept    = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    // A write to XZR is consumed here but never stored.
    assign push      = accept && (push_rd != XZR);

    // The head entry drives the register file whenever one exists and hold
    // is low. The outputs read zero when the queue is empty.
    assign rf_regwr  = !empty && !hold;
    assign pop       = rf_regwr;
    assign rf_rd     = empty ? '0 : entry_rd[head];
    assign rf_datawr = empty ? '0 : entry_data[head];

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, cleared on reset so that discarded writes leave no residue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_rd[i]   <= '0;
                entry_data[i] <= '0;
            end
        end else if (push) begin
            entry_rd[tail]   <= push_rd;
            entry_data[tail] <= push_data;
        end
    end

    // Forwarding scan walks from oldest to youngest so the last match (youngest) wins
    always_comb begin
        logic [PW-1:0] idx;
        fwd_rn_hit  = 1'b0;
        fwd_rn_data = '0;
        fwd_rm_hit  = 1'b0;
        fwd_rm_data = '0;
        idx         = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count_q) begin
                if ((entry_rd[idx] == fwd_rn) && (fwd_rn != XZR)) begin
                    fwd_rn_hit  = 1'b1;
                    fwd_rn_data = entry_data[idx];
                end
                if ((entry_rd[idx] == fwd_rm) && (fwd_rm != XZR)) begin
                    fwd_rm_hit  = 1'b1;
                    fwd_rm_data = entry_data[idx];
                end
            end
        end
    end

endmodule
